// File: rtl/calc_disp_pkg.sv
// Shared types, constants and segment encoding for the result display path.
package calc_disp_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} disp_state_t;

  localparam int NUM_BCD    = 5;
  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 never occur and map to blank.
  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // 16-bit unsigned magnitude; -32768 yields 32768.
  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 16 shift cycles plus a commit cycle,
// with a one-deep latest-wins queue for starts that arrive while busy.
module bin2bcd_seq
  import calc_disp_pkg::*;
(
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd,
  output logic        sign
);

  disp_state_t state_q, state_d;
  logic [19:0] bcd_q, bcd_d;
  logic [15:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        pend_vld_q, pend_vld_d;
  logic [15:0] pend_mag_q, pend_mag_d;
  logic        pend_sign_q, pend_sign_d;

  logic [19:0] adj;
  logic        load;
  logic [15:0] load_mag;
  logic        load_sign;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BCD; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? (bcd_q[4*gi +: 4] + 4'd3)
                                                         : bcd_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      mag_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_mag_q  <= '0;
      pend_sign_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      pend_vld_q  <= pend_vld_d;
      pend_mag_q  <= pend_mag_d;
      pend_sign_q <= pend_sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == 5'd15) state_d = COMMIT;
      COMMIT:  state_d = (start || pend_vld_q) ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == COMMIT);
    bcd  = bcd_q;
    sign = sign_q;
  end

  // A start seen during COMMIT bypasses the queue since it is the newest value.
  always_comb begin
    load      = ((state_q == IDLE) && start) ||
                ((state_q == COMMIT) && (start || pend_vld_q));
    load_mag  = start ? abs16(value) : pend_mag_q;
    load_sign = start ? value[15] : pend_sign_q;

    bcd_d       = bcd_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    pend_vld_d  = pend_vld_q;
    pend_mag_d  = pend_mag_q;
    pend_sign_d = pend_sign_q;

    if (state_q == SHIFT) begin
      {bcd_d, mag_d} = {adj[18:0], mag_q, 1'b0};
      cnt_d          = cnt_q + 5'd1;
      if (start) begin
        pend_vld_d  = 1'b1;
        pend_mag_d  = abs16(value);
        pend_sign_d = value[15];
      end
    end

    if (state_q == COMMIT) pend_vld_d = 1'b0;

    if (load) begin
      bcd_d  = '0;
      cnt_d  = '0;
      mag_d  = load_mag;
      sign_d = load_sign;
    end
  end

endmodule

// File: rtl/result_display_driver.sv
// Edge-triggered BCD conversion of a signed result, shown on a 6-digit
// multiplexed active-low 7-segment display (sign plus five digits).
module result_display_driver
  import calc_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] result,
  input  logic        result_valid,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        busy,
  output logic        bcd_valid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  // arm_q is 1 only after result_valid was seen low, so a level held high
  // across reset release never starts a conversion.
  logic arm_q;
  logic start;

  logic [19:0] conv_bcd;
  logic        conv_sign;
  logic        conv_done;

  logic [19:0] disp_bcd_q, disp_bcd_d;
  logic        disp_sign_q, disp_sign_d;
  logic [CW-1:0] ref_q, ref_d;
  logic        wrap;
  logic        scan_en_q, scan_en_d;
  logic [2:0]  dig_q, dig_d;
  logic [6:0]  seg_q, seg_d;
  logic [5:0]  an_q, an_d;
  logic [NUM_BCD-1:0] hi_zero;
  logic [6:0]  digit_seg [NUM_DIGITS];

  assign start = result_valid & arm_q;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .nRST  (nRST),
    .start (start),
    .value (result),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .sign  (conv_sign)
  );

  assign bcd_valid = conv_done;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      arm_q       <= 1'b0;
      disp_bcd_q  <= '0;
      disp_sign_q <= 1'b0;
      ref_q       <= '0;
      scan_en_q   <= 1'b0;
      dig_q       <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      arm_q       <= ~result_valid;
      disp_bcd_q  <= disp_bcd_d;
      disp_sign_q <= disp_sign_d;
      ref_q       <= ref_d;
      scan_en_q   <= scan_en_d;
      dig_q       <= dig_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  always_comb begin
    disp_bcd_d  = conv_done ? conv_bcd  : disp_bcd_q;
    disp_sign_d = conv_done ? conv_sign : disp_sign_q;

    wrap      = (ref_q == CW'(REFRESH_DIV - 1));
    ref_d     = wrap ? '0 : ref_q + {{(CW-1){1'b0}}, 1'b1};
    scan_en_d = scan_en_q | wrap;
    dig_d     = dig_q;
    if (wrap && scan_en_q) dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
  end

  // Digit content is taken from the next-state display value so a commit is
  // visible on the very next cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BCD; gi++) begin : g_digit
      assign hi_zero[gi] = ~|disp_bcd_d[4*NUM_BCD-1 : 4*gi];
      if (gi == 0) begin : g_units
        assign digit_seg[gi] = seg_lut(disp_bcd_d[3:0]);
      end else begin : g_upper
        assign digit_seg[gi] = (BLANK_LEADING && hi_zero[gi]) ? SEG_BLANK
                                                              : seg_lut(disp_bcd_d[4*gi +: 4]);
      end
    end
  endgenerate

  assign digit_seg[NUM_DIGITS-1] = disp_sign_d ? SEG_MINUS : SEG_BLANK;

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    if (scan_en_d) begin
      seg_d = digit_seg[dig_d];
      an_d  = ~(6'b000001 << dig_d);
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed bench for result_display_driver: conversion latency, scanned digit
// content, leading-zero blanking, start queueing and asynchronous reset.
module tb_result_display_driver;

  localparam int DIV = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SM = 7'b0111111;

  logic        clk = 1'b0;
  logic        nRST;
  logic [15:0] result;
  logic        result_valid;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        busy;
  logic        bcd_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic [15:0] val;
    logic [41:0] exp;   // {digit5 .. digit0}
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  result_display_driver #(.REFRESH_DIV(DIV), .BLANK_LEADING(1'b1)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .result       (result),
    .result_valid (result_valid),
    .seg          (seg),
    .an           (an),
    .busy         (busy),
    .bcd_valid    (bcd_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scan_check(input string name, input logic [41:0] exp);
    logic [6:0] got [6];
    logic [5:0] seen = '0;
    logic [5:0] pat;
    int bad = 0;
    bit hit;
    for (int i = 0; i < 6; i++) got[i] = 7'bx;
    for (int c = 0; c < 12 * DIV; c++) begin
      @(negedge clk);
      if (an !== 6'h3f) begin
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
          pat = ~(6'b000001 << i);
          if (an === pat) begin
            got[i]  = seg;
            seen[i] = 1'b1;
            hit     = 1'b1;
          end
        end
        if (!hit) bad++;
      end
    end
    check({name, " onehot"}, 64'(bad), 64'd0);
    check({name, " seen"}, 64'(seen), 64'h3f);
    for (int i = 0; i < 6; i++) check($sformatf("%s digit%0d", name, i), 64'(got[i]), 64'(exp[7*i +: 7]));
    $display("[TB] scan %s done", name);
  endtask

  task automatic run_conv(input string name, input logic [15:0] v);
    int first = 0;
    int pulses = 0;
    logic busy1 = 1'b0;
    @(negedge clk) result_valid = 1'b0;
    @(negedge clk) begin result = v; result_valid = 1'b1; end
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (bcd_valid) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    check({name, " latency"}, 64'(first), 64'd17);
    check({name, " pulses"}, 64'(pulses), 64'd1);
    check({name, " busy_start"}, 64'(busy1), 64'd1);
    check({name, " busy_end"}, 64'(busy), 64'd0);
    $display("[TB] conv %s value=%h bcd_valid at +%0d", name, v, first);
    result_valid = 1'b0;
  endtask

  task automatic quiet_check(input string name, input int cycles);
    int act = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bcd_valid || busy) act++;
    end
    check({name, " quiet"}, 64'(act), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"zero",   16'd0,     {SB, SB, SB, SB, SB, S0}};
    vecs[1] = '{"p12",    16'd12,    {SB, SB, SB, SB, S1, S2}};
    vecs[2] = '{"p100",   16'd100,   {SB, SB, SB, S1, S0, S0}};
    vecs[3] = '{"p1575",  16'd1575,  {SB, SB, S1, S5, S7, S5}};
    vecs[4] = '{"m32768", 16'h8000,  {SM, S3, S2, S7, S6, S8}};
    vecs[5] = '{"p32767", 16'h7FFF,  {SB, S3, S2, S7, S6, S7}};
    vecs[6] = '{"m1",     16'hFFFF,  {SM, SB, SB, SB, SB, S1}};
    vecs[7] = '{"m10000", 16'hD8F0,  {SM, S1, S0, S0, S0, S0}};
    vecs[8] = '{"m9",     16'hFFF7,  {SM, SB, SB, SB, SB, S9}};

    // Reset with result_valid already high: must not trigger a conversion.
    nRST = 1'b0;
    result = 16'd0;
    result_valid = 1'b1;
    repeat (3) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    check("rst seg", 64'(seg), 64'h7f);
    check("rst an", 64'(an), 64'h3f);
    check("rst busy", 64'(busy), 64'd0);
    check("rst bcd_valid", 64'(bcd_valid), 64'd0);
    quiet_check("held_valid", 30);
    scan_check("after_reset", {SB, SB, SB, SB, SB, S0});

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].name, vecs[i].val);
      scan_check(vecs[i].name, vecs[i].exp);
    end

    // Starts at N, N+5, N+8: 3 commits at N+17, queued 5 shifts from N+18
    // and commits at N+34; 4 is overwritten in the queue.
    begin
      int p1 = 0, p2 = 0, extra = 0;
      int old_bad = 0, old_seen = 0, mid_bad = 0, mid_seen = 0, four_seen = 0;
      @(negedge clk) result_valid = 1'b0;
      @(negedge clk) begin result = 16'd3; result_valid = 1'b1; end
      for (int k = 1; k <= 45; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (bcd_valid) begin
          if (p1 == 0) p1 = k;
          else if (p2 == 0) p2 = k;
          else extra++;
        end
        if (an === 6'b111110) begin
          if (k <= 17) begin old_seen++; if (seg !== S9) old_bad++; end
          else if (k <= 34) begin mid_seen++; if (seg !== S3) mid_bad++; end
          if (seg === S4) four_seen++;
        end
        case (k)
          3: result_valid = 1'b0;
          5: begin result = 16'd4; result_valid = 1'b1; end
          7: result_valid = 1'b0;
          8: begin result = 16'd5; result_valid = 1'b1; end
          9: result_valid = 1'b0;
          default: ;
        endcase
      end
      check("queue first pulse", 64'(p1), 64'd17);
      check("queue second pulse", 64'(p2), 64'd34);
      check("queue extra pulses", 64'(extra), 64'd0);
      check("queue old shown", 64'(old_bad + (old_seen == 0 ? 1 : 0)), 64'd0);
      check("queue three shown", 64'(mid_bad + (mid_seen == 0 ? 1 : 0)), 64'd0);
      check("queue four never", 64'(four_seen), 64'd0);
      $display("[TB] queue pulses at +%0d and +%0d", p1, p2);
      scan_check("queue_final", {SB, SB, SB, SB, SB, S5});
    end

    // Asynchronous reset in the middle of converting 1575.
    begin
      int pulses = 0;
      @(negedge clk) result_valid = 1'b0;
      @(negedge clk) begin result = 16'd1575; result_valid = 1'b1; end
      for (int k = 1; k <= 8; k++) begin
        @(posedge clk);
        @(negedge clk);
        if (bcd_valid) pulses++;
      end
      check("midrst busy_before", 64'(busy), 64'd1);
      nRST = 1'b0;
      #1;
      check("midrst seg", 64'(seg), 64'h7f);
      check("midrst an", 64'(an), 64'h3f);
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst bcd_valid", 64'(bcd_valid), 64'd0);
      repeat (2) @(negedge clk);
      result_valid = 1'b0;
      nRST = 1'b1;
      check("midrst no pulse before", 64'(pulses), 64'd0);
      quiet_check("midrst_after", 30);
      scan_check("midrst_display", {SB, SB, SB, SB, SB, S0});
      $display("[TB] mid-conversion reset done");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
